// File: rtl/present_dec_if.sv
// rtl/present_dec_if.sv - valid/ready bus bundle for the PRESENT-80 decryptor
//
// Groups the producer handshake (ivalid/iready/idat/ikey) and the consumer
// handshake (ovalid/oready/odat) of present_dec.
//   slave  : the decryptor side
//   master : the producer/consumer side driving ciphertext and taking plaintext
`timescale 1ns/1ps

interface present_dec_if;
    logic        ivalid;
    logic        iready;
    logic [63:0] idat;
    logic [79:0] ikey;
    logic        ovalid;
    logic        oready;
    logic [63:0] odat;

    modport slave (
        input  ivalid, idat, ikey, oready,
        output iready, ovalid, odat
    );

    modport master (
        output ivalid, idat, ikey, oready,
        input  iready, ovalid, odat
    );
endinterface

// File: rtl/present_dec.sv
// rtl/present_dec.sv - iterative PRESENT-80 block decryptor, one block in flight
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : present_dec_if.slave
//          ivalid/iready/idat[63:0]/ikey[79:0] ciphertext + master key in
//          ovalid/oready/odat[63:0]            plaintext out
// Latency: transfer edge T -> ovalid from edge T+63.
`timescale 1ns/1ps

module present_dec (
    input  logic          clk,
    input  logic          rst,
    present_dec_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, KEYX, DEC, FIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] st_q, st_d;
    logic [79:0] kr_q, kr_d;
    logic [4:0]  rc_q, rc_d;
    logic [63:0] odat_q, odat_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'h6; 4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9; 4'h5: sbox = 4'h0; 4'h6: sbox = 4'hA; 4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'hE; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'h7; 4'hE: sbox = 4'h1; default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: inv_sbox = 4'h5; 4'h1: inv_sbox = 4'hE; 4'h2: inv_sbox = 4'hF; 4'h3: inv_sbox = 4'h8;
            4'h4: inv_sbox = 4'hC; 4'h5: inv_sbox = 4'h1; 4'h6: inv_sbox = 4'h2; 4'h7: inv_sbox = 4'hD;
            4'h8: inv_sbox = 4'hB; 4'h9: inv_sbox = 4'h4; 4'hA: inv_sbox = 4'h6; 4'hB: inv_sbox = 4'h3;
            4'hC: inv_sbox = 4'h0; 4'hD: inv_sbox = 4'h7; 4'hE: inv_sbox = 4'h9; default: inv_sbox = 4'hA;
        endcase
    endfunction

    // Output bit i takes input bit (16*i mod 63); bit 63 is a fixed point.
    function automatic logic [63:0] inv_perm(input logic [63:0] x);
        logic [63:0] y;
        logic [5:0]  src;
        y[63] = x[63];
        for (int i = 0; i < 63; i++) begin
            src  = 6'((16 * i) % 63);
            y[i] = x[src];
        end
        return y;
    endfunction

    function automatic logic [63:0] inv_sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 16; j++) begin
            y[4*j +: 4] = inv_sbox(x[4*j +: 4]);
        end
        return y;
    endfunction

    // Forward schedule step: K_{r} -> K_{r+1} using round index r.
    function automatic logic [79:0] key_fwd(input logic [79:0] x, input logic [4:0] r);
        logic [79:0] k;
        k          = {x[18:0], x[79:19]};
        k[79:76]   = sbox(k[79:76]);
        k[19:15]   = k[19:15] ^ r;
        return k;
    endfunction

    // Exact undo of key_fwd: K_{r+1} -> K_{r}.
    function automatic logic [79:0] key_inv(input logic [79:0] x, input logic [4:0] r);
        logic [79:0] k;
        k          = x;
        k[19:15]   = k[19:15] ^ r;
        k[79:76]   = inv_sbox(k[79:76]);
        return {k[60:0], k[79:61]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            kr_q    <= '0;
            rc_q    <= '0;
            odat_q  <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            kr_q    <= kr_d;
            rc_q    <= rc_d;
            odat_q  <= odat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        kr_d    = kr_q;
        rc_d    = rc_q;
        odat_d  = odat_q;
        case (state_q)
            IDLE: begin
                if (bus.ivalid) begin
                    st_d    = bus.idat;
                    kr_d    = bus.ikey;
                    rc_d    = 5'd1;
                    state_d = KEYX;
                end
            end
            KEYX: begin
                kr_d = key_fwd(kr_q, rc_q);
                // rc stays at 31 so DEC starts by undoing the last key step.
                if (rc_q == 5'd31) state_d = DEC;
                else               rc_d    = rc_q + 5'd1;
            end
            DEC: begin
                st_d = inv_sbox_layer(inv_perm(st_q ^ kr_q[79:16]));
                kr_d = key_inv(kr_q, rc_q);
                // rc is left at 1 on exit so it never reads 0 while busy.
                if (rc_q == 5'd1) state_d = FIN;
                else              rc_d    = rc_q - 5'd1;
            end
            FIN: begin
                odat_d  = st_q ^ kr_q[79:16];
                state_d = DONE;
            end
            DONE: begin
                if (bus.oready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.iready = (state_q == IDLE);
    assign bus.ovalid = (state_q == DONE);
    assign bus.odat   = odat_q;

endmodule

// File: tb/tb_present_dec.sv
// tb/tb_present_dec.sv - self-checking bench for present_dec
`timescale 1ns/1ps

module tb_present_dec;

    logic clk = 1'b0;
    logic rst;

    present_dec_if bus ();

    present_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] ct;
        logic [79:0] key;
        logic [63:0] pt;
    } vec_t;

    localparam logic [79:0] KEY_F = {80{1'b1}};
    localparam logic [63:0] ALL_F = {64{1'b1}};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference PRESENT-80 encryption, written from the forward cipher definition.
    function automatic logic [3:0] ref_s(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[4*x +: 4];
    endfunction

    function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s, t;
        logic [79:0] k;
        logic [5:0]  dst;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int j = 0; j < 16; j++) t[4*j +: 4] = ref_s(s[4*j +: 4]);
            s[63] = t[63];
            for (int i = 0; i < 63; i++) begin
                dst    = 6'((16 * i) % 63);
                s[dst] = t[i];
            end
            k        = {k[18:0], k[79:19]};
            k[79:76] = ref_s(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Counts negedges from the transfer until ovalid; 63 is the required latency.
    task automatic wait_ovalid(output int n);
        n = 0;
        while (!bus.ovalid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_block(input logic [63:0] ct, input logic [79:0] key,
                             input logic [63:0] exp, input int stall, input string name);
        int n;
        @(negedge clk);
        bus.ivalid = 1'b1;
        bus.idat   = ct;
        bus.ikey   = key;
        @(negedge clk);
        bus.ivalid = 1'b0;
        bus.idat   = {$urandom, $urandom};
        bus.ikey   = {$urandom, $urandom, 16'($urandom)};
        wait_ovalid(n);
        check({name, "_latency"}, 80'(n), 80'd63);
        repeat (stall) @(negedge clk);
        check({name, "_odat"}, 80'(bus.odat), 80'(exp));
        bus.oready = 1'b1;
        @(negedge clk);
        bus.oready = 1'b0;
        check({name, "_release"}, {78'd0, bus.ovalid, bus.iready}, 80'b01);
    endtask

    initial begin
        vec_t tbl[4];
        int   n, bad;
        logic [63:0] pt, ct;
        logic [79:0] key;

        tbl[0] = '{ct: 64'h5579C1387B228445, key: 80'h0,  pt: 64'h0};
        tbl[1] = '{ct: 64'hE72C46C0F5945049, key: KEY_F,  pt: 64'h0};
        tbl[2] = '{ct: 64'hA112FFC72F68417B, key: 80'h0,  pt: ALL_F};
        tbl[3] = '{ct: 64'h3333DCD3213210D2, key: KEY_F,  pt: ALL_F};

        rst        = 1'b1;
        bus.ivalid = 1'b0;
        bus.oready = 1'b0;
        bus.idat   = '0;
        bus.ikey   = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {14'd0, bus.iready, bus.ovalid, bus.odat}, {14'd0, 1'b1, 1'b0, 64'd0});

        // Transfer attempted while rst is high must be dropped.
        bus.ivalid = 1'b1;
        bus.idat   = tbl[0].ct;
        @(negedge clk);
        rst        = 1'b0;
        bus.ivalid = 1'b0;
        @(negedge clk);
        check("reset_discard", 80'(bus.iready), 80'd1);

        for (int v = 0; v < 4; v++) begin
            run_block(tbl[v].ct, tbl[v].key, tbl[v].pt, 0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_odat_hold", v), 80'(bus.odat), 80'(tbl[v].pt));
        end

        // Consumer stall: output and handshake hold for 20 cycles.
        @(negedge clk);
        bus.ivalid = 1'b1;
        bus.idat   = tbl[3].ct;
        bus.ikey   = tbl[3].key;
        @(negedge clk);
        bus.ivalid = 1'b0;
        wait_ovalid(n);
        check("stall_latency", 80'(n), 80'd63);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!bus.ovalid || bus.odat !== ALL_F || bus.iready) bad++;
        end
        check("stall_hold", 80'(bad), 80'd0);
        bus.oready = 1'b1;
        @(negedge clk);
        bus.oready = 1'b0;
        check("stall_release", {78'd0, bus.ovalid, bus.iready}, 80'b01);

        // Back-to-back with ivalid and oready tied high.
        @(negedge clk);
        bus.ivalid = 1'b1;
        bus.oready = 1'b1;
        bus.idat   = tbl[0].ct;
        bus.ikey   = tbl[0].key;
        @(negedge clk);
        bus.idat   = 64'hDEADBEEF01234567;
        bus.ikey   = 80'h0123456789ABCDEF0123;
        wait_ovalid(n);
        check("b2b_first_latency", 80'(n), 80'd63);
        check("b2b_first_odat", 80'(bus.odat), 80'(tbl[0].pt));
        bus.idat = tbl[1].ct;
        bus.ikey = tbl[1].key;
        @(negedge clk);
        check("b2b_pulse_idle", {78'd0, bus.ovalid, bus.iready}, 80'b01);
        @(negedge clk);
        check("b2b_second_accept", 80'(bus.iready), 80'd0);
        bus.ivalid = 1'b0;
        wait_ovalid(n);
        check("b2b_second_latency", 80'(n), 80'd63);
        check("b2b_second_odat", 80'(bus.odat), 80'(tbl[1].pt));
        @(negedge clk);
        check("b2b_second_pulse", 80'(bus.ovalid), 80'd0);
        bus.oready = 1'b0;

        // Reset asserted one cycle at transfer+40, inside DEC.
        @(negedge clk);
        bus.ivalid = 1'b1;
        bus.idat   = tbl[0].ct;
        bus.ikey   = tbl[0].key;
        @(negedge clk);
        bus.ivalid = 1'b0;
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {78'd0, bus.ovalid, bus.iready}, 80'b01);
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.ovalid || !bus.iready) bad++;
        end
        check("abort_quiet", 80'(bad), 80'd0);
        run_block(tbl[0].ct, tbl[0].key, tbl[0].pt, 0, "after_abort");

        // Random plaintext/key pairs through the reference encryptor.
        for (int b = 0; b < 1000; b++) begin
            pt  = {$urandom, $urandom};
            key = {$urandom, $urandom, 16'($urandom)};
            ct  = ref_enc(pt, key);
            run_block(ct, key, pt, $urandom_range(0, 2), $sformatf("rand%0d", b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
